// File: rtl/ldm_stm_sequencer_if.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer_if
// Data-memory request/acknowledge bus between the load/store-multiple
// sequencer (master) and the data memory (slave).
//
// Signals:
//   memReq    master -> slave  beat request, held until acknowledged
//   memWe     master -> slave  1 = write beat, 0 = read beat
//   memAddr   master -> slave  word address of the current beat
//   memWdata  master -> slave  store data
//   memAck    slave -> master  beat completes on the edge where req && ack
//   memRdata  slave -> master  load data, valid while memAck is high
// ---------------------------------------------------------------------------
interface ldm_stm_sequencer_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memAck;
  logic [31:0] memRdata;

  // The sequencer drives the request side and samples the response side.
  modport master (
    output memReq,
    output memWe,
    output memAddr,
    output memWdata,
    input  memAck,
    input  memRdata
  );

  // The memory sees the request side and answers with ack/data.
  modport slave (
    input  memReq,
    input  memWe,
    input  memAddr,
    input  memWdata,
    output memAck,
    output memRdata
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
// Multi-cycle load/store-multiple engine. Takes a 16-bit register list and a
// base address, walks the list one register per memory beat (ascending
// register index at ascending address), then optionally writes the final
// address back to the base register.
//
// Ports:
//   clk          clock, all state changes on posedge
//   reset        synchronous, active-high
//   i_start      request pulse, only looked at in IDLE
//   i_isLoad     1 = LDM, 0 = STM
//   i_regList    bit i set -> transfer Ri
//   i_rn         base register index
//   i_base       current value of Rn
//   i_up         1 = increment, 0 = decrement
//   i_pre        1 = adjust before, 0 = after
//   i_wb         write final address back to Rn
//   o_busy       high in every state except IDLE
//   o_done       one-cycle completion pulse
//   o_rfRaddr    register-file read address (stores)
//   i_rfRdata    register-file read data, combinational from o_rfRaddr
//   o_rfWe       register-file write enable
//   o_rfWaddr    register-file write address
//   o_rfWdata    register-file write data
//   memBus       data-memory request/ack bus (master side)
// ---------------------------------------------------------------------------
module ldm_stm_sequencer (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic                        i_isLoad,
  input  logic [15:0]                 i_regList,
  input  logic [3:0]                  i_rn,
  input  logic [31:0]                 i_base,
  input  logic                        i_up,
  input  logic                        i_pre,
  input  logic                        i_wb,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [3:0]                  o_rfRaddr,
  input  logic [31:0]                 i_rfRdata,
  output logic                        o_rfWe,
  output logic [3:0]                  o_rfWaddr,
  output logic [31:0]                 o_rfWdata,
  ldm_stm_sequencer_if.master         memBus
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    XFER,
    WB,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_isLoad;
  logic [15:0] r_regList;
  logic [15:0] r_remain;
  logic [3:0]  r_rn;
  logic [31:0] r_base;
  logic        r_up;
  logic        r_pre;
  logic        r_wb;
  logic [31:0] r_addr;
  logic [31:0] r_final;

  logic [4:0]  w_count;
  logic [31:0] w_span;
  logic [31:0] w_startAddr;
  logic [31:0] w_finalAddr;
  logic [3:0]  w_cur;
  logic [15:0] w_lowBit;
  logic [15:0] w_remainNext;
  logic        w_wbBlocked;

  // Register count and the address arithmetic derived from it. The four
  // addressing modes all reduce to "lowest transferred address" so that the
  // beat loop can always step upwards by 4.
  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_count = w_count + {4'd0, r_regList[i]};
    end
    w_span = {25'd0, w_count, 2'b00};
    case ({r_up, r_pre})
      2'b10:   w_startAddr = r_base;
      2'b11:   w_startAddr = r_base + 32'd4;
      2'b00:   w_startAddr = r_base - w_span + 32'd4;
      default: w_startAddr = r_base - w_span;
    endcase
    w_finalAddr = r_up ? (r_base + w_span) : (r_base - w_span);
  end

  // Pick the lowest register still pending. The one-hot isolate trick
  // (x & -x) gives the bit to clear once the beat is acknowledged.
  always_comb begin
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_remain[i]) begin
        w_cur = 4'(i);
      end
    end
    w_lowBit     = r_remain & (~r_remain + 16'd1);
    w_remainNext = r_remain & ~w_lowBit;
    w_wbBlocked  = r_isLoad && r_regList[r_rn];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operand latch and beat bookkeeping. Everything the operation needs is
  // captured at the start edge so the decode side is free afterwards; the
  // address and pending list only move on an acknowledged beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_isLoad  <= 1'b0;
      r_regList <= 16'd0;
      r_remain  <= 16'd0;
      r_rn      <= 4'd0;
      r_base    <= 32'd0;
      r_up      <= 1'b0;
      r_pre     <= 1'b0;
      r_wb      <= 1'b0;
      r_addr    <= 32'd0;
      r_final   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_isLoad  <= i_isLoad;
            r_regList <= i_regList;
            r_remain  <= i_regList;
            r_rn      <= i_rn;
            r_base    <= i_base;
            r_up      <= i_up;
            r_pre     <= i_pre;
            r_wb      <= i_wb;
          end
        end
        CALC: begin
          r_addr  <= w_startAddr;
          r_final <= w_finalAddr;
        end
        XFER: begin
          if (memBus.memAck) begin
            r_remain <= w_remainNext;
            r_addr   <= r_addr + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and all outputs. Outputs are zero outside the states that
  // own them, so the load write (XFER) and base writeback (WB) can never
  // overlap. Writes and the done pulse are suppressed during a reset cycle
  // so an aborted operation leaves no partial side effects.
  always_comb begin
    w_nextState     = r_state;
    o_busy          = (r_state != IDLE);
    o_done          = 1'b0;
    o_rfRaddr       = 4'd0;
    o_rfWe          = 1'b0;
    o_rfWaddr       = 4'd0;
    o_rfWdata       = 32'd0;
    memBus.memReq   = 1'b0;
    memBus.memWe    = 1'b0;
    memBus.memAddr  = 32'd0;
    memBus.memWdata = 32'd0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        w_nextState = (w_count == 5'd0) ? DONE : XFER;
      end
      XFER: begin
        memBus.memReq  = 1'b1;
        memBus.memWe   = !r_isLoad;
        memBus.memAddr = r_addr;
        if (r_isLoad) begin
          o_rfWe    = memBus.memAck;
          o_rfWaddr = w_cur;
          o_rfWdata = memBus.memRdata;
        end else begin
          o_rfRaddr       = w_cur;
          memBus.memWdata = i_rfRdata;
        end
        if (memBus.memAck && (w_remainNext == 16'd0)) begin
          w_nextState = WB;
        end
      end
      WB: begin
        if (r_wb && !w_wbBlocked) begin
          o_rfWe    = 1'b1;
          o_rfWaddr = r_rn;
          o_rfWdata = r_final;
        end
        w_nextState = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (reset) begin
      o_rfWe = 1'b0;
      o_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ldm_stm_sequencer
// Directed self-checking bench for ldm_stm_sequencer. A small register-file
// and memory responder answer the DUT; each operation is logged cycle by
// cycle and compared against hand-computed beats, writes and latencies.
// ---------------------------------------------------------------------------
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        isLoad;
  logic [15:0] regList;
  logic [3:0]  rn;
  logic [31:0] base;
  logic        up;
  logic        pre;
  logic        wb;
  logic        busy;
  logic        done;
  logic [3:0]  rfRaddr;
  logic [31:0] rfRdata;
  logic        rfWe;
  logic [3:0]  rfWaddr;
  logic [31:0] rfWdata;

  ldm_stm_sequencer_if memBus ();

  ldm_stm_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (start),
    .i_isLoad  (isLoad),
    .i_regList (regList),
    .i_rn      (rn),
    .i_base    (base),
    .i_up      (up),
    .i_pre     (pre),
    .i_wb      (wb),
    .o_busy    (busy),
    .o_done    (done),
    .o_rfRaddr (rfRaddr),
    .i_rfRdata (rfRdata),
    .o_rfWe    (rfWe),
    .o_rfWaddr (rfWaddr),
    .o_rfWdata (rfWdata),
    .memBus    (memBus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Register file contents seen by stores; only the stimulus writes it, the
  // DUT's writes are checked from the log instead.
  logic [31:0] regFile [16];
  assign rfRdata = regFile[rfRaddr];

  // Memory read data is a fixed function of the address.
  function automatic logic [31:0] memValue(input logic [31:0] a);
    case (a)
      32'h100: memValue = 32'h0000_00A0;
      32'h104: memValue = 32'h0000_00A2;
      32'h108: memValue = 32'h0000_00A5;
      32'h044: memValue = 32'h1111_0044;
      32'h048: memValue = 32'h2222_0048;
      32'h080: memValue = 32'h0000_0055;
      default: memValue = {16'hD000, a[15:0]};
    endcase
  endfunction

  // Ack responder: acks every request except for stallLen cycles on beat
  // number stallBeat (0-based).
  int   beatIdx;
  int   stallCnt;
  int   stallBeat;
  int   stallLen;
  logic clearCounters;

  assign memBus.memAck   = memBus.memReq && !((beatIdx == stallBeat) && (stallCnt < stallLen));
  assign memBus.memRdata = memBus.memAck ? memValue(memBus.memAddr) : 32'd0;

  always @(posedge clk) begin
    if (clearCounters) begin
      beatIdx  <= 0;
      stallCnt <= 0;
    end else if (memBus.memReq) begin
      if (memBus.memAck) beatIdx  <= beatIdx + 1;
      else               stallCnt <= stallCnt + 1;
    end
  end

  // Per-operation log.
  logic [31:0] beatAddr [$];
  logic [31:0] beatData [$];
  logic        beatWe   [$];
  logic [3:0]  rfAddrQ  [$];
  logic [31:0] rfDataQ  [$];
  int          doneCycle;
  logic        busyAt1;
  int          reqCycles;
  int          watchCount;
  int          stallWe;
  int          postActivity;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Launch one operation and log it until done (bounded), then watch a few
  // idle cycles. glitchCycle > 0 fires a second start with different
  // operands while the first operation is busy.
  task automatic applyStimulus(input logic loadOp, input logic [15:0] list, input logic [3:0] baseReg,
                               input logic [31:0] baseAddr, input logic goUp, input logic preIdx,
                               input logic doWb, input int sBeat, input int sLen, input int glitchCycle);
    @(negedge clk);
    stallBeat     = sBeat;
    stallLen      = sLen;
    clearCounters = 1'b1;
    @(negedge clk);
    clearCounters = 1'b0;
    isLoad  = loadOp;
    regList = list;
    rn      = baseReg;
    base    = baseAddr;
    up      = goUp;
    pre     = preIdx;
    wb      = doWb;
    start   = 1'b1;
    beatAddr.delete(); beatData.delete(); beatWe.delete();
    rfAddrQ.delete();  rfDataQ.delete();
    doneCycle = 0; busyAt1 = 1'b0; reqCycles = 0; watchCount = 0; stallWe = 0; postActivity = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == glitchCycle) begin
        start   = 1'b1;
        isLoad  = ~loadOp;
        regList = 16'hFFFF;
        base    = 32'h0000_0999;
        rn      = 4'd9;
      end
      if (cyc == 1) busyAt1 = busy;
      if (memBus.memReq) begin
        reqCycles++;
        if (memBus.memAddr == 32'h48) watchCount++;
        if (!memBus.memAck && rfWe) stallWe++;
      end
      if (memBus.memReq && memBus.memAck) begin
        beatAddr.push_back(memBus.memAddr);
        beatWe.push_back(memBus.memWe);
        beatData.push_back(memBus.memWe ? memBus.memWdata : memBus.memRdata);
      end
      if (rfWe) begin
        rfAddrQ.push_back(rfWaddr);
        rfDataQ.push_back(rfWdata);
      end
      if (done) begin
        doneCycle = cyc;
        break;
      end
    end
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || rfWe || memBus.memReq) postActivity++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; isLoad = 1'b0; regList = 16'd0; rn = 4'd0;
    base = 32'd0; up = 1'b0; pre = 1'b0; wb = 1'b0;
    stallBeat = 0; stallLen = 0; clearCounters = 1'b1;
    for (int i = 0; i < 16; i++) regFile[i] = 32'hEE00_0000 | i;
    regFile[1]  = 32'h11;
    regFile[14] = 32'h22;
    regFile[0]  = 32'hC0;
    regFile[15] = 32'hF15;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst busy",     {31'd0, busy}, 32'd0);
    checkOutput("rst done",     {31'd0, done}, 32'd0);
    checkOutput("rst rfWe",     {31'd0, rfWe}, 32'd0);
    checkOutput("rst memReq",   {31'd0, memBus.memReq}, 32'd0);
    checkOutput("rst memWe",    {31'd0, memBus.memWe}, 32'd0);
    checkOutput("rst memAddr",  memBus.memAddr, 32'd0);
    checkOutput("rst memWdata", memBus.memWdata, 32'd0);
    checkOutput("rst rfRaddr",  {28'd0, rfRaddr}, 32'd0);
    checkOutput("rst rfWaddr",  {28'd0, rfWaddr}, 32'd0);
    checkOutput("rst rfWdata",  rfWdata, 32'd0);
    reset = 1'b0;

    // LDM IA, wb=1
    applyStimulus(1'b1, 16'h0025, 4'd13, 32'h100, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("ia done cycle", doneCycle, 32'd6);
    checkOutput("ia busy c1",    {31'd0, busyAt1}, 32'd1);
    checkOutput("ia beats",      beatAddr.size(), 32'd3);
    checkOutput("ia addr0",      beatAddr[0], 32'h100);
    checkOutput("ia addr1",      beatAddr[1], 32'h104);
    checkOutput("ia addr2",      beatAddr[2], 32'h108);
    checkOutput("ia we0",        {31'd0, beatWe[0]}, 32'd0);
    checkOutput("ia rf writes",  rfAddrQ.size(), 32'd4);
    checkOutput("ia rf0 addr",   {28'd0, rfAddrQ[0]}, 32'd0);
    checkOutput("ia rf0 data",   rfDataQ[0], 32'hA0);
    checkOutput("ia rf1 addr",   {28'd0, rfAddrQ[1]}, 32'd2);
    checkOutput("ia rf1 data",   rfDataQ[1], 32'hA2);
    checkOutput("ia rf2 addr",   {28'd0, rfAddrQ[2]}, 32'd5);
    checkOutput("ia rf2 data",   rfDataQ[2], 32'hA5);
    checkOutput("ia wb addr",    {28'd0, rfAddrQ[3]}, 32'd13);
    checkOutput("ia wb data",    rfDataQ[3], 32'h10C);
    checkOutput("ia post idle",  postActivity, 32'd0);

    // STM DB, wb=1
    applyStimulus(1'b0, 16'h4002, 4'd4, 32'h200, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    checkOutput("db done cycle", doneCycle, 32'd5);
    checkOutput("db beats",      beatAddr.size(), 32'd2);
    checkOutput("db addr0",      beatAddr[0], 32'h1F8);
    checkOutput("db data0",      beatData[0], 32'h11);
    checkOutput("db we0",        {31'd0, beatWe[0]}, 32'd1);
    checkOutput("db addr1",      beatAddr[1], 32'h1FC);
    checkOutput("db data1",      beatData[1], 32'h22);
    checkOutput("db rf writes",  rfAddrQ.size(), 32'd1);
    checkOutput("db wb addr",    {28'd0, rfAddrQ[0]}, 32'd4);
    checkOutput("db wb data",    rfDataQ[0], 32'h1F8);

    // LDM IB with 3 stall cycles on beat 2, no writeback
    applyStimulus(1'b1, 16'h0003, 4'd7, 32'h40, 1'b1, 1'b1, 1'b0, 1, 3, 0);
    checkOutput("stall done cycle", doneCycle, 32'd8);
    checkOutput("stall addr0",      beatAddr[0], 32'h44);
    checkOutput("stall addr1",      beatAddr[1], 32'h48);
    checkOutput("stall req@48",     watchCount, 32'd4);
    checkOutput("stall rfWe early", stallWe, 32'd0);
    checkOutput("stall rf writes",  rfAddrQ.size(), 32'd2);
    checkOutput("stall rf0 data",   rfDataQ[0], 32'h1111_0044);
    checkOutput("stall rf1 addr",   {28'd0, rfAddrQ[1]}, 32'd1);
    checkOutput("stall rf1 data",   rfDataQ[1], 32'h2222_0048);

    // LDM with base register in the list: loaded value wins
    applyStimulus(1'b1, 16'h0004, 4'd2, 32'h80, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("inlist done cycle", doneCycle, 32'd4);
    checkOutput("inlist rf writes",  rfAddrQ.size(), 32'd1);
    checkOutput("inlist rf addr",    {28'd0, rfAddrQ[0]}, 32'd2);
    checkOutput("inlist rf data",    rfDataQ[0], 32'h55);

    // Empty list
    applyStimulus(1'b1, 16'h0000, 4'd5, 32'h500, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("empty done cycle", doneCycle, 32'd2);
    checkOutput("empty busy c1",    {31'd0, busyAt1}, 32'd1);
    checkOutput("empty req cycles", reqCycles, 32'd0);
    checkOutput("empty rf writes",  rfAddrQ.size(), 32'd0);

    // STM DA with R15 and the base register in the list (store still writes back)
    applyStimulus(1'b0, 16'h8001, 4'd0, 32'h300, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    checkOutput("da done cycle", doneCycle, 32'd5);
    checkOutput("da addr0",      beatAddr[0], 32'h2FC);
    checkOutput("da data0",      beatData[0], 32'hC0);
    checkOutput("da addr1",      beatAddr[1], 32'h300);
    checkOutput("da data1",      beatData[1], 32'hF15);
    checkOutput("da rf writes",  rfAddrQ.size(), 32'd1);
    checkOutput("da wb data",    rfDataQ[0], 32'h2F8);

    // Start while busy is ignored
    applyStimulus(1'b1, 16'h0003, 4'd3, 32'h40, 1'b1, 1'b0, 1'b1, 0, 0, 2);
    checkOutput("glitch done cycle", doneCycle, 32'd5);
    checkOutput("glitch beats",      beatAddr.size(), 32'd2);
    checkOutput("glitch addr1",      beatAddr[1], 32'h44);
    checkOutput("glitch rf writes",  rfAddrQ.size(), 32'd3);
    checkOutput("glitch rf0 data",   rfDataQ[0], 32'hD000_0040);
    checkOutput("glitch wb addr",    {28'd0, rfAddrQ[2]}, 32'd3);
    checkOutput("glitch wb data",    rfDataQ[2], 32'h48);
    checkOutput("glitch post idle",  postActivity, 32'd0);

    // Reset during the first XFER beat
    @(negedge clk);
    stallBeat = 0; stallLen = 0; clearCounters = 1'b1;
    @(negedge clk);
    clearCounters = 1'b0;
    isLoad = 1'b0; regList = 16'h0003; rn = 4'd6; base = 32'h300;
    up = 1'b1; pre = 1'b0; wb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstx in xfer", {31'd0, memBus.memReq}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstx busy",   {31'd0, busy}, 32'd0);
    checkOutput("rstx memReq", {31'd0, memBus.memReq}, 32'd0);
    checkOutput("rstx done",   {31'd0, done}, 32'd0);
    reset = 1'b0;
    postActivity = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done || rfWe || memBus.memReq) postActivity++;
    end
    checkOutput("rstx quiet", postActivity, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle load/store-multiple engine that drives the register file from the other side of its ports. It accepts a 16-bit register list and a base address, then walks the list one register per memory beat. Loads write memory data into the register file; stores read registers out to memory. It finishes with an optional base-register writeback. It sits between the decode/control path, the register file's read, write and writeback ports, and the data-memory request/acknowledge interface.

## Interface
Parameters:
- none; data and address width fixed at 32, register index at 4 (R0–R15)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- reglist  in  16  bit i set → transfer Ri
- rn  in  4  base register index
- base  in  32  current value of Rn
- up  in  1  1 = increment, 0 = decrement
- pre  in  1  1 = before, 0 = after
- wb  in  1  write final address back to Rn
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rf_raddr  out  4  register-file read address (stores)
- rf_rdata  in  32  register-file read data; combinational from rf_raddr
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wdata  out  32  register-file write data
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write beat
- mem_addr  out  32  word address of the current beat
- mem_wdata  out  32  store data
- mem_ack  in  1  beat completes on the posedge where mem_req and mem_ack are both high
- mem_rdata  in  32  load data; valid while mem_ack is high

## Operation
- States: IDLE → CALC → XFER → WB → DONE → IDLE.
- IDLE, start=1: latch is_load, reglist, rn, base, up, pre, wb. Go to CALC.
- CALC (one cycle):
  - N = popcount(reglist), 5-bit.
  - Start address: IA = base; IB = base+4; DA = base−4N+4; DB = base−4N.
  - Final address: up ? base+4N : base−4N.
  - All arithmetic is modulo 2^32.
  - If N=0, go directly to DONE: no memory beat, no writeback.
- XFER:
  - cur = lowest set bit remaining in the list. Registers always go in ascending index order at ascending addresses.
  - mem_req=1, mem_we=!is_load, mem_addr = current address.
  - Store: rf_raddr=cur, mem_wdata=rf_rdata. R15 reads as whatever the register file returns.
  - Load: rf_we=mem_ack, rf_waddr=cur, rf_wdata=mem_rdata, all in the ack cycle. Loading R15 is allowed.
  - On ack: clear bit cur, address += 4. When the list empties, go to WB.
  - Without ack: all outputs hold stable.
- WB (one cycle):
  - rf_we=1, rf_waddr=rn, rf_wdata = final address, only if wb=1.
  - Exception: no write if is_load=1 and bit rn of the latched list is set. The loaded value wins.
- DONE: done=1 for one cycle, then IDLE.
- rf_we is never asserted in two states in the same cycle. The load write and the base writeback never coincide.
- start while busy is ignored and not queued.
- Inputs other than the ack/data pair are don't-care after the latch.

## Timing
- Reset values: busy=0, done=0, rf_we=0, mem_req=0, mem_we=0; rf_raddr, rf_waddr, rf_wdata, mem_addr, mem_wdata = 0.
- Reset in any state returns to IDLE at that edge:
  - no done pulse;
  - mem_req low from the following cycle;
  - no partial writeback.
- Latency with start accepted at edge E0 and ack every cycle:
  - CALC in cycle 1;
  - XFER in cycles 2..N+1;
  - WB in cycle N+2;
  - done in cycle N+3.
- N=0: done in cycle 2.
- Each ack stall cycle adds one cycle.
- busy rises in cycle 1 and falls after the done cycle.
- A new start is accepted on the edge ending the done cycle at the earliest, since the block is in IDLE in the next cycle.

## Test plan
- LDM IA, wb=1:
  - Stimulus: base=0x100, rn=13, reglist=0x0025, ack every cycle, rdata=0xA0/0xA2/0xA5.
  - Required: mem_addr 0x100, 0x104, 0x108; writes R0=0xA0, R2=0xA2, R5=0xA5; WB writes R13=0x10C; done in cycle 6.
- STM DB, wb=1:
  - Stimulus: base=0x200, reglist=0x4002, R1=0x11, R14=0x22.
  - Required: writes 0x11@0x1F8, 0x22@0x1FC; WB writes Rn=0x1F8.
- Memory stall:
  - Stimulus: ack withheld 3 cycles on beat 2 of LDM IB, base=0x40, reglist=0x0003.
  - Required: mem_addr=0x48, mem_req stable for 4 cycles; no rf_we until ack; done delayed 3 cycles.
- Base in list:
  - Stimulus: LDM, rn=2, reglist=0x0004, wb=1, rdata=0x55.
  - Required: R2=0x55 written during XFER; no rf_we in WB.
- Empty list:
  - Stimulus: reglist=0.
  - Required: no mem_req, no rf_we; done in cycle 2.
- Reset mid-XFER, then start while busy:
  - Stimulus: reset asserted during beat 1; separately, a start pulse issued while busy.
  - Required: reset gives busy=0, mem_req=0, no done. The start while busy is ignored, and the in-flight operation completes unchanged.
